memwb_skid_stage: RTL and testbench
===================================

Name: memwb_skid_stage

Overview:
- Parametrised MEM/WB pipeline stage with a valid/ready handshake and a 2-entry skid buffer.
- Full throughput, with stall and flush support.
- Sits between the data-memory stage and register-file writeback.
- Replaces the fixed-width, always-advancing stage register; lets writeback back-pressure MEM without combinational ready paths.

Parameters:
- DATA_W, 64, width of ReadData/AluResult.
- RD_W, 5, destination register index width.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- flush  input  1  synchronous kill of all held entries.
- in_valid  input  1  MEM side presents an entry.
- in_ready  output  1  stage can accept (registered).
- MemToReg  input  1  writeback source select.
- RegWrite  input  1  register write enable.
- ReadData  input  DATA_W  memory load data.
- AluResult  input  DATA_W  ALU result.
- rd  input  RD_W  destination register.
- out_valid  output  1  head entry valid.
- out_ready  input  1  writeback consumes head.
- MemToRegOut  output  1  head MemToReg.
- RegWriteOut  output  1  qualified write enable.
- ReadDataOut  output  DATA_W  head ReadData.
- AluResultOut  output  DATA_W  head AluResult.
- rdOut  output  RD_W  head rd.
- occupancy  output  2  entries held (0..2).

Behaviour:
- Storage: main register (head, drives outputs) and skid register; states EMPTY(0), ONE(1), FULL(2).
- Reset (reset=0, async):
  - state EMPTY, in_ready=1, out_valid=0, occupancy=0.
  - All data outputs and both registers zero.
- Handshakes:
  - accept = in_valid & in_ready.
  - pop = out_valid & out_ready.
- in_ready = (state != FULL), driven from a flop, never combinational from out_ready.
- Transitions (flush=0):
  - EMPTY: accept -> ONE (entry into main).
  - ONE: accept & pop -> ONE (main replaced); accept & !pop -> FULL (entry into skid); pop & !accept -> EMPTY; else hold.
  - FULL: pop -> ONE (skid moves to main, skid cleared); no accept possible; else hold.
- Latency:
  - Accepted entry appears on outputs the next cycle when the stage is EMPTY, or ONE with pop.
  - Throughput is 1 entry/cycle while out_ready=1.
- Ordering: strict FIFO; the skid entry is never output before main.
- Flush:
  - Next state EMPTY regardless of accept/pop; the accept in the flush cycle is discarded.
  - in_ready=1 the following cycle.
  - Data registers may retain stale values, but RegWriteOut=0.
- RegWriteOut = stored RegWrite & out_valid & (rdOut != 0). Writes to x0 and bubbles never assert it.
- Other outputs show the head entry's stored fields. When out_valid=0 they are don't-care, but must not change except on a load.
- occupancy mirrors the state encoding (0/1/2).
- Reset asserted mid-transfer: entries are lost and outputs return to reset values immediately, without waiting for a clock edge.

Optional Feature:
- Macro MEMWB_WBMUX_EN.
- Defined:
  - Adds output WbDataOut, DATA_W wide = MemToRegOut ? ReadDataOut : AluResultOut.
  - Computed at load time and stored as a per-entry register, not a combinational mux on the outputs.
  - Reset value 0; moves with the entry through the skid path.
- Undefined: port and storage absent; all other behaviour identical.

Test Plan:
- Reset: hold reset=0 with in_valid=1 -> out_valid=0, in_ready=1, occupancy=0, all outputs 0. Release -> first accept AluResult=0x10, rd=3, RegWrite=1 appears next cycle with RegWriteOut=1.
- Streaming: out_ready=1, 8 back-to-back entries AluResult=1..8 -> outputs 1..8 on consecutive cycles, in_ready constantly 1, occupancy never 2.
- Back-pressure: out_ready=0, send A=0xA, B=0xB -> occupancy=2, in_ready=0, C held by source. out_ready=1 -> outputs A, B, C in order, no loss or duplication.
- Flush: in FULL state, flush=1 with in_valid=1 -> next cycle out_valid=0, RegWriteOut=0, occupancy=0; the entry offered in the flush cycle never appears.
- x0 write: RegWrite=1, rd=0, AluResult=0x55 -> out_valid=1, AluResultOut=0x55, RegWriteOut=0.
- MEMWB_WBMUX_EN defined: entry MemToReg=1, ReadData=0x1234, AluResult=0x99 -> WbDataOut=0x1234. MemToReg=0 -> WbDataOut=0x99, including after passing through the skid register.

Source files
------------

// File: rtl/memwb_skid_stage.sv
// MEM/WB pipeline stage: valid/ready handshake with a 2-entry skid buffer (main + skid).
// Optional feature: define MEMWB_WBMUX_EN to add the registered writeback-data output WbDataOut.
module memwb_skid_stage #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned RD_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              MemToReg,
  input  logic              RegWrite,
  input  logic [DATA_W-1:0] ReadData,
  input  logic [DATA_W-1:0] AluResult,
  input  logic [RD_W-1:0]   rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              MemToRegOut,
  output logic              RegWriteOut,
  output logic [DATA_W-1:0] ReadDataOut,
  output logic [DATA_W-1:0] AluResultOut,
  output logic [RD_W-1:0]   rdOut,
  output logic [1:0]        occupancy
`ifdef MEMWB_WBMUX_EN
  ,
  output logic [DATA_W-1:0] WbDataOut
`endif
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } stateT;

  typedef struct packed {
    logic              memToReg;
    logic              regWrite;
    logic [DATA_W-1:0] readData;
    logic [DATA_W-1:0] aluResult;
    logic [RD_W-1:0]   rd;
`ifdef MEMWB_WBMUX_EN
    logic [DATA_W-1:0] wbData;
`endif
  } entryT;

  stateT stateQ, stateD;
  entryT mainQ, mainD;
  entryT skidQ, skidD;
  entryT inEntry;
  logic  inReadyQ;
  logic  outValidQ;
  logic  accept;
  logic  pop;
  logic  loadMainIn;
  logic  loadMainSkid;
  logic  loadSkid;
  logic  clearSkid;

  assign accept = in_valid & inReadyQ;
  assign pop    = outValidQ & out_ready;

  always_comb begin
    inEntry           = '0;
    inEntry.memToReg  = MemToReg;
    inEntry.regWrite  = RegWrite;
    inEntry.readData  = ReadData;
    inEntry.aluResult = AluResult;
    inEntry.rd        = rd;
`ifdef MEMWB_WBMUX_EN
    // Writeback select resolved at load so the output is a plain flop.
    inEntry.wbData    = MemToReg ? ReadData : AluResult;
`endif
  end

  always_comb begin
    stateD       = stateQ;
    loadMainIn   = 1'b0;
    loadMainSkid = 1'b0;
    loadSkid     = 1'b0;
    clearSkid    = 1'b0;
    case (stateQ)
      StEmpty: begin
        if (accept) begin
          stateD     = StOne;
          loadMainIn = 1'b1;
        end
      end
      StOne: begin
        if (accept && pop) begin
          loadMainIn = 1'b1;
        end else if (accept) begin
          stateD   = StFull;
          loadSkid = 1'b1;
        end else if (pop) begin
          stateD = StEmpty;
        end
      end
      StFull: begin
        if (pop) begin
          stateD       = StOne;
          loadMainSkid = 1'b1;
          clearSkid    = 1'b1;
        end
      end
      default: stateD = StEmpty;
    endcase
    // Flush drops everything, including a same-cycle accept; data regs keep stale values.
    if (flush) begin
      stateD       = StEmpty;
      loadMainIn   = 1'b0;
      loadMainSkid = 1'b0;
      loadSkid     = 1'b0;
      clearSkid    = 1'b0;
    end
  end

  always_comb begin
    mainD = mainQ;
    if (loadMainIn) begin
      mainD = inEntry;
    end else if (loadMainSkid) begin
      mainD = skidQ;
    end
  end

  always_comb begin
    skidD = skidQ;
    if (loadSkid) begin
      skidD = inEntry;
    end else if (clearSkid) begin
      skidD = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ    <= StEmpty;
      mainQ     <= '0;
      skidQ     <= '0;
      inReadyQ  <= 1'b1;
      outValidQ <= 1'b0;
    end else begin
      stateQ    <= stateD;
      mainQ     <= mainD;
      skidQ     <= skidD;
      inReadyQ  <= (stateD != StFull);
      outValidQ <= (stateD != StEmpty);
    end
  end

  assign in_ready     = inReadyQ;
  assign out_valid    = outValidQ;
  assign occupancy    = stateQ;
  assign MemToRegOut  = mainQ.memToReg;
  assign ReadDataOut  = mainQ.readData;
  assign AluResultOut = mainQ.aluResult;
  assign rdOut        = mainQ.rd;
  // Bubbles and writes to x0 never reach the register file.
  assign RegWriteOut  = mainQ.regWrite & outValidQ & (mainQ.rd != '0);
`ifdef MEMWB_WBMUX_EN
  assign WbDataOut    = mainQ.wbData;
`endif

endmodule

// File: tb/tb_memwb_skid_stage.sv
// Directed self-checking bench for memwb_skid_stage; expected values are hand-computed constants.
module tb_memwb_skid_stage;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned RD_W   = 5;

  logic              clk;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic              MemToReg;
  logic              RegWrite;
  logic [DATA_W-1:0] ReadData;
  logic [DATA_W-1:0] AluResult;
  logic [RD_W-1:0]   rd;
  logic              out_valid;
  logic              out_ready;
  logic              MemToRegOut;
  logic              RegWriteOut;
  logic [DATA_W-1:0] ReadDataOut;
  logic [DATA_W-1:0] AluResultOut;
  logic [RD_W-1:0]   rdOut;
  logic [1:0]        occupancy;
`ifdef MEMWB_WBMUX_EN
  logic [DATA_W-1:0] WbDataOut;
`endif

  int compared;
  int mismatched;

  memwb_skid_stage #(
    .DATA_W(DATA_W),
    .RD_W  (RD_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .MemToReg    (MemToReg),
    .RegWrite    (RegWrite),
    .ReadData    (ReadData),
    .AluResult   (AluResult),
    .rd          (rd),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .MemToRegOut (MemToRegOut),
    .RegWriteOut (RegWriteOut),
    .ReadDataOut (ReadDataOut),
    .AluResultOut(AluResultOut),
    .rdOut       (rdOut),
    .occupancy   (occupancy)
`ifdef MEMWB_WBMUX_EN
    ,
    .WbDataOut   (WbDataOut)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic m2r, input logic rw, input logic [63:0] rdata,
                       input logic [63:0] alu, input logic [4:0] dst);
    in_valid  = v;
    MemToReg  = m2r;
    RegWrite  = rw;
    ReadData  = rdata;
    AluResult = alu;
    rd        = dst;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b0;
    flush      = 1'b0;
    out_ready  = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 64'hDEAD, 64'hBEEF, 5'd7);

    // Reset held with in_valid high
    step();
    step();
    checkEq("rst_out_valid", {63'd0, out_valid}, 64'd0);
    checkEq("rst_in_ready", {63'd0, in_ready}, 64'd1);
    checkEq("rst_occupancy", {62'd0, occupancy}, 64'd0);
    checkEq("rst_alu", AluResultOut, 64'd0);
    checkEq("rst_rdata", ReadDataOut, 64'd0);
    checkEq("rst_rd", {59'd0, rdOut}, 64'd0);
    checkEq("rst_regwrite", {63'd0, RegWriteOut}, 64'd0);
    checkEq("rst_memtoreg", {63'd0, MemToRegOut}, 64'd0);
`ifdef MEMWB_WBMUX_EN
    checkEq("rst_wbdata", WbDataOut, 64'd0);
`endif
    reset = 1'b1;

    // First accept after reset
    drive(1'b1, 1'b0, 1'b1, 64'h0, 64'h10, 5'd3);
    step();
    checkEq("first_valid", {63'd0, out_valid}, 64'd1);
    checkEq("first_alu", AluResultOut, 64'h10);
    checkEq("first_rd", {59'd0, rdOut}, 64'd3);
    checkEq("first_regwrite", {63'd0, RegWriteOut}, 64'd1);
    checkEq("first_occ", {62'd0, occupancy}, 64'd1);
    drive(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 5'd0);
    out_ready = 1'b1;
    step();
    checkEq("first_drain_occ", {62'd0, occupancy}, 64'd0);
    checkEq("first_drain_valid", {63'd0, out_valid}, 64'd0);

    // Streaming at full throughput
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 1'b0, 1'b1, 64'h0, 64'(i), 5'(i));
      step();
      checkEq($sformatf("stream_alu_%0d", i), AluResultOut, 64'(i));
      checkEq($sformatf("stream_valid_%0d", i), {63'd0, out_valid}, 64'd1);
      checkEq($sformatf("stream_ready_%0d", i), {63'd0, in_ready}, 64'd1);
      checkEq($sformatf("stream_occ_%0d", i), {62'd0, occupancy}, 64'd1);
    end
    drive(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 5'd0);
    step();
    checkEq("stream_drain_occ", {62'd0, occupancy}, 64'd0);

    // Back-pressure: A, B fill the stage, C is held by the source
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 64'h0, 64'hA, 5'd1);
    step();
    checkEq("bp_occ_a", {62'd0, occupancy}, 64'd1);
    drive(1'b1, 1'b0, 1'b1, 64'h0, 64'hB, 5'd2);
    step();
    checkEq("bp_occ_full", {62'd0, occupancy}, 64'd2);
    checkEq("bp_in_ready", {63'd0, in_ready}, 64'd0);
    checkEq("bp_head_a", AluResultOut, 64'hA);
    drive(1'b1, 1'b0, 1'b1, 64'h0, 64'hC, 5'd3);
    step();
    checkEq("bp_hold_occ", {62'd0, occupancy}, 64'd2);
    checkEq("bp_hold_head", AluResultOut, 64'hA);
    out_ready = 1'b1;
    step();
    checkEq("bp_head_b", AluResultOut, 64'hB);
    checkEq("bp_occ_b", {62'd0, occupancy}, 64'd1);
    checkEq("bp_ready_b", {63'd0, in_ready}, 64'd1);
    step();
    checkEq("bp_head_c", AluResultOut, 64'hC);
    checkEq("bp_rd_c", {59'd0, rdOut}, 64'd3);
    drive(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 5'd0);
    step();
    checkEq("bp_drain_occ", {62'd0, occupancy}, 64'd0);
    checkEq("bp_drain_valid", {63'd0, out_valid}, 64'd0);

    // Flush from FULL with a new entry offered
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 64'h0, 64'h21, 5'd4);
    step();
    drive(1'b1, 1'b0, 1'b1, 64'h0, 64'h22, 5'd5);
    step();
    checkEq("fl_occ_full", {62'd0, occupancy}, 64'd2);
    flush = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 64'h0, 64'h99, 5'd6);
    step();
    flush = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 5'd0);
    checkEq("fl_valid", {63'd0, out_valid}, 64'd0);
    checkEq("fl_regwrite", {63'd0, RegWriteOut}, 64'd0);
    checkEq("fl_occ", {62'd0, occupancy}, 64'd0);
    checkEq("fl_ready", {63'd0, in_ready}, 64'd1);

    // Flush from ONE discards the same-cycle accept
    drive(1'b1, 1'b0, 1'b1, 64'h0, 64'h31, 5'd4);
    step();
    flush = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 64'h0, 64'h77, 5'd8);
    step();
    flush = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 5'd0);
    checkEq("fl1_valid", {63'd0, out_valid}, 64'd0);
    out_ready = 1'b1;
    step();
    checkEq("fl1_still_empty", {63'd0, out_valid}, 64'd0);
    checkEq("fl1_occ", {62'd0, occupancy}, 64'd0);

    // Write to x0 is never qualified
    drive(1'b1, 1'b0, 1'b1, 64'h0, 64'h55, 5'd0);
    step();
    drive(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 5'd0);
    checkEq("x0_valid", {63'd0, out_valid}, 64'd1);
    checkEq("x0_alu", AluResultOut, 64'h55);
    checkEq("x0_regwrite", {63'd0, RegWriteOut}, 64'd0);
    step();
    checkEq("x0_drain", {63'd0, out_valid}, 64'd0);

    // Writeback select fields, second entry passes through the skid register
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 64'h1234, 64'h99, 5'd9);
    step();
    checkEq("wb1_memtoreg", {63'd0, MemToRegOut}, 64'd1);
    checkEq("wb1_rdata", ReadDataOut, 64'h1234);
`ifdef MEMWB_WBMUX_EN
    checkEq("wb1_wbdata", WbDataOut, 64'h1234);
`endif
    drive(1'b1, 1'b0, 1'b1, 64'h4321, 64'h99, 5'd10);
    step();
    drive(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 5'd0);
    checkEq("wb2_occ", {62'd0, occupancy}, 64'd2);
    out_ready = 1'b1;
    step();
    checkEq("wb2_memtoreg", {63'd0, MemToRegOut}, 64'd0);
    checkEq("wb2_rdata", ReadDataOut, 64'h4321);
    checkEq("wb2_rd", {59'd0, rdOut}, 64'd10);
`ifdef MEMWB_WBMUX_EN
    checkEq("wb2_wbdata", WbDataOut, 64'h99);
`endif
    step();
    checkEq("wb_drain", {62'd0, occupancy}, 64'd0);

    // Asynchronous reset while FULL
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 64'h0, 64'h41, 5'd1);
    step();
    drive(1'b1, 1'b0, 1'b1, 64'h0, 64'h42, 5'd2);
    step();
    drive(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 5'd0);
    checkEq("ar_occ_full", {62'd0, occupancy}, 64'd2);
    #2;
    reset = 1'b0;
    #1;
    checkEq("ar_valid", {63'd0, out_valid}, 64'd0);
    checkEq("ar_occ", {62'd0, occupancy}, 64'd0);
    checkEq("ar_ready", {63'd0, in_ready}, 64'd1);
    checkEq("ar_alu", AluResultOut, 64'd0);
    reset = 1'b1;
    step();
    checkEq("ar_after_valid", {63'd0, out_valid}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
